mul_digit_seq: RTL and testbench
================================

# mul_digit_seq

Sequential WIDTH×WIDTH unsigned multiplier controller that time-shares a single 2×2 multiplier cell. It walks every pair of 2-bit operand digits, one pair per clock, and accumulates the shifted partial products into a 2·WIDTH result register. It sits between a start/done requester (lab top level or CPU-side register block) and the combinational `multiplier2x2` cell, trading area for latency.

## Interface
- WIDTH, 8, operand width in bits; even, ≥ 4; D = WIDTH/2 digits per operand.
- clk  in  1  rising-edge system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only while ready = 1.
- a  in  WIDTH  multiplicand (unsigned); latched when start is accepted.
- b  in  WIDTH  multiplier (unsigned); latched when start is accepted.
- ready  out  1  high only in IDLE; decoded from state.
- busy  out  1  high in RUN.
- done  out  1  single-cycle pulse; product valid.
- product  out  2·WIDTH  last completed result; holds until the next completion.

## Operation
- States: IDLE → RUN → DONE → IDLE.
- IDLE:
  - start = 1 latches a and b into a_r and b_r.
  - Clears acc, i, j to 0, then → RUN.
  - start = 0: stay in IDLE.
- RUN, each cycle:
  - Cell inputs: A = a_r[2i+1:2i], B = b_r[2j+1:2j].
  - pp = 4-bit cell output.
  - acc ← acc + (pp << 2·(i+j)).
  - j increments; when j wraps from D−1 to 0, i increments.
- RUN exit: on the cycle with i = D−1 and j = D−1:
  - product ← acc + final shifted pp.
  - done ← 1, → DONE.
- DONE: done = 1 for exactly this cycle, then → IDLE.
- Width rules:
  - acc and product are 2·WIDTH bits.
  - Shifted pp is zero-extended to 2·WIDTH bits.
  - No overflow is possible.
  - i and j are max(1, $clog2(D)) bits.
- start while busy or in DONE: ignored, no queuing. a/b changes after acceptance have no effect.
- Reset (any time, including mid-RUN):
  - state = IDLE, acc = 0, product = 0, done = 0, i = j = 0.
  - ready = 1, busy = 0.
  - An operation in progress is abandoned and produces no done.

## Timing
- Accept edge = t0. RUN occupies the D² cycles after t0.
- done is high in the cycle following edge t0 + D² (16 edges for WIDTH = 8). product updates on that same edge.
- ready is low from t0+1 through the DONE cycle and high again at t0 + D² + 1.
- Minimum start-to-start interval: D² + 2 cycles.
- Held-high start gives back-to-back operations.
- Outputs are registered, except ready and busy, which are pure state decode. There is no combinational path from start/a/b to any output.

## Structure
- Shared package holds:
  - State encoding localparams: ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2.
  - Digit-count helper: D = WIDTH/2, counter width.
- Single sub-module: one instance of `multiplier2x2` (2-bit × 2-bit → 4-bit).
  - Digit muxes, shifter, accumulator and FSM live in mul_digit_seq.
  - No second cell instance.

## Test plan
- Reset, then idle:
  - ready = 1, busy = 0, done = 0, product = 16'h0000.
- a = 8'h0D, b = 8'h0B, 1-cycle start:
  - busy for 16 cycles.
  - done pulse 16 cycles after the accept edge.
  - product = 16'h008F.
- a = 8'hFF, b = 8'hFF → product = 16'hFE01.
- a = 8'h00, b = 8'hA5 → product = 16'h0000, with the same 16-cycle latency.
- Mid-run input changes:
  - At cycle 5 of RUN, set a = 8'h12, b = 8'h34 and pulse start.
  - Start is ignored; the original result is unchanged.
  - Exactly one done pulse.
- Reset and back-to-back:
  - Assert rst_n = 0 at cycle 8 of RUN: no done, product = 0, ready = 1 immediately.
  - Then hold start high with operands 8'h03 × 8'h07: results 16'h0015 every 18 cycles.
  - Random 1,000-vector compare against a×b.

Source files
------------

// File: rtl/mul_digit_seq_pkg.sv
// Shared encodings and sizing helpers for the digit-serial multiplier.
package mul_digit_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StDone = ST_DONE
  } state_e;

  function automatic int unsigned num_digits(input int unsigned width);
    return width / 2;
  endfunction

  // Digit counters need at least one bit even when there is a single digit.
  function automatic int unsigned cnt_width(input int unsigned width);
    int unsigned c;
    c = $clog2(num_digits(width));
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/mul_digit_seq_multiplier2x2.sv
// Combinational 2-bit x 2-bit unsigned multiplier cell.
module multiplier2x2 (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  output logic [3:0] p_o
);

  assign p_o = {2'b00, a_i} * {2'b00, b_i};

endmodule

// File: rtl/mul_digit_seq.sv
// Sequential Width x Width multiplier that walks every digit pair through one 2x2 cell,
// accumulating shifted partial products.
module mul_digit_seq
  import mul_digit_seq_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [Width-1:0]   a_i,
  input  logic [Width-1:0]   b_i,
  output logic               ready_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*Width-1:0] product_o
);

  localparam int unsigned D    = num_digits(Width);
  localparam int unsigned CntW = cnt_width(Width);
  localparam logic [CntW-1:0] Last = CntW'(D - 1);

  state_e               state_q;
  logic [Width-1:0]     a_q, b_q;
  logic [2*Width-1:0]   acc_q, product_q;
  logic [CntW-1:0]      i_q, j_q;
  logic                 done_q;

  logic [1:0]           dig_a, dig_b;
  logic [3:0]           pp;
  logic [CntW:0]        dig_sum;
  logic [2*Width-1:0]   pp_sh, acc_next;

  assign dig_a = a_q[2*i_q +: 2];
  assign dig_b = b_q[2*j_q +: 2];

  multiplier2x2 u_cell (
    .a_i (dig_a),
    .b_i (dig_b),
    .p_o (pp)
  );

  // Digit weight is 4^(i+j), i.e. a shift of 2*(i+j) bits.
  assign dig_sum  = {1'b0, i_q} + {1'b0, j_q};
  assign pp_sh    = {{(2*Width-4){1'b0}}, pp} << {dig_sum, 1'b0};
  assign acc_next = acc_q + pp_sh;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
      i_q       <= '0;
      j_q       <= '0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          acc_q <= acc_next;
          if (i_q == Last && j_q == Last) begin
            product_q <= acc_next;
            done_q    <= 1'b1;
            state_q   <= StDone;
          end else if (j_q == Last) begin
            j_q <= '0;
            i_q <= i_q + 1'b1;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ready_o   = (state_q == StIdle);
  assign busy_o    = (state_q == StRun);
  assign done_o    = done_q;
  assign product_o = product_q;

endmodule

// File: tb/tb_mul_digit_seq.sv
// Directed and randomised checks for mul_digit_seq with WIDTH = 8.
module tb_mul_digit_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a, b;
  logic        ready, busy, done;
  logic [15:0] product;

  int checks = 0;
  int errors = 0;

  mul_digit_seq #(.Width(8)) dut (
    .clk_i     (clk),
    .rst_n     (rst_n),
    .start_i   (start),
    .a_i       (a),
    .b_i       (b),
    .ready_o   (ready),
    .busy_o    (busy),
    .done_o    (done),
    .product_o (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full operation with cycle-exact timing checks; operands are scrambled after accept.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        input logic [15:0] exp, input string tag);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check1({tag, " busy"}, busy, 1'b1);
      check1({tag, " early done"}, done, 1'b0);
    end
    @(negedge clk);
    check1({tag, " done"}, done, 1'b1);
    check1({tag, " ready in done"}, ready, 1'b0);
    check16({tag, " product"}, product, exp);
    @(negedge clk);
    check1({tag, " done width"}, done, 1'b0);
    check1({tag, " ready after"}, ready, 1'b1);
  endtask

  initial begin
    int n_done;
    int gap;
    logic [15:0] cap;
    logic [7:0]  ra, rb;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check1("reset ready", ready, 1'b1);
    check1("reset busy", busy, 1'b0);
    check1("reset done", done, 1'b0);
    check16("reset product", product, 16'h0000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check1("idle ready", ready, 1'b1);

    run_op(8'h0D, 8'h0B, 16'h008F, "0Dx0B");
    run_op(8'hFF, 8'hFF, 16'hFE01, "FFxFF");
    run_op(8'h00, 8'hA5, 16'h0000, "00xA5");
    run_op(8'h0D, 8'h0B, 16'h008F, "0Dx0B again");

    // Start pulse and operand change mid-run must be ignored.
    @(negedge clk);
    a = 8'h0D; b = 8'h0B; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    a = 8'h12; b = 8'h34; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_done = 0; cap = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        cap = product;
      end
    end
    check_int("midrun done count", n_done, 1);
    check16("midrun product", cap, 16'h008F);

    // Reset mid-run abandons the operation.
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check1("pre-reset busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check1("async reset ready", ready, 1'b1);
    check1("async reset busy", busy, 1'b0);
    check16("async reset product", product, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check_int("abandoned done count", n_done, 0);
    check16("abandoned product", product, 16'h0000);

    // Held start: back-to-back results every 18 cycles.
    @(negedge clk);
    a = 8'h03; b = 8'h07; start = 1'b1;
    gap = 0;
    while (!done && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    check1("b2b first done", done, 1'b1);
    check16("b2b first product", product, 16'h0015);
    for (int r = 0; r < 3; r++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (!done && gap < 40);
      check_int("b2b interval", gap, 18);
      check16("b2b product", product, 16'h0015);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check1("b2b idle", ready, 1'b1);

    for (int v = 0; v < 1000; v++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op(ra, rb, {8'h00, ra} * {8'h00, rb}, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
